// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage and the data memory.
// The stage is the master: it drives the request, address, lanes and
// store data; the memory answers with dAck and dRdata.
interface mem_access_if;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dBe;
  logic        dAck;
  logic [31:0] dRdata;

  modport master (
    output dReq, dWe, dAddr, dWdata, dBe,
    input  dAck, dRdata
  );

  modport slave (
    input  dReq, dWe, dAddr, dWdata, dBe,
    output dAck, dRdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory results pass through with one
// cycle of latency. Aligned loads/stores run one request/acknowledge bus
// transaction while stalling upstream. Misaligned accesses complete
// immediately without touching the bus. An optional timeout aborts a
// transaction that never gets acknowledged.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inValid,
  input  logic               memRd,
  input  logic               memWr,
  input  logic [2:0]         memCtrl,
  input  logic [31:0]        aluOut,
  input  logic [31:0]        r2,
  input  logic [4:0]         rdIn,
  input  logic               regWrIn,
  output logic               stall,
  mem_access_if.master       dbus,
  output logic               outValid,
  output logic [4:0]         rdOut,
  output logic               regWrOut,
  output logic [31:0]        wbData,
  output logic               misalign,
  output logic               busErr
);

  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_t;

  // funct3[1:0] selects the access size: 00 byte, 01 half, anything else
  // (word and the illegal encodings) behaves as a word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Picks the addressed lane out of the bus word and extends it; funct3[2]
  // distinguishes the unsigned variants.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b100:  return {24'd0, b};
      3'b001:  return 32'(h);
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [4:0]         rd_q, rd_d;
  logic               rw_q, rw_d;
  logic               ov_q, ov_d;
  logic [4:0]         rdOut_q, rdOut_d;
  logic               rwOut_q, rwOut_d;
  logic [31:0]        wb_q, wb_d;
  logic               mis_q, mis_d;
  logic               berr_q, berr_d;

  logic is_mem, aligned, accept, busy, to_hit, done;

  assign is_mem  = memRd | memWr;
  assign aligned = is_aligned(memCtrl, aluOut[1:0]);
  assign accept  = (state_q == IDLE) & inValid & is_mem & aligned;
  assign busy    = (state_q == BUSY);
  assign to_hit  = (TIMEOUT != 0) && busy && !dbus.dAck && (cnt_q == CNT_W'(TO_LAST));
  assign done    = busy & (dbus.dAck | to_hit);

  // Upstream advances on the edge that finishes a transaction, so the held
  // instruction is never seen again in IDLE.
  assign stall = accept | (busy & ~done);

  assign dbus.dReq   = busy;
  assign dbus.dWe    = we_q;
  assign dbus.dAddr  = {addr_q[31:2], 2'b00};
  assign dbus.dWdata = wdata_q;
  assign dbus.dBe    = be_q;

  assign outValid = ov_q;
  assign rdOut    = rdOut_q;
  assign regWrOut = rwOut_q;
  assign wbData   = wb_q;
  assign misalign = mis_q;
  assign busErr   = berr_q;

  // Next-state and write-back payload selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ctrl_d  = ctrl_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ov_d    = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    rdOut_d = rdOut_q;
    rwOut_d = rwOut_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          if (!is_mem) begin
            ov_d    = 1'b1;
            wb_d    = aluOut;
            rdOut_d = rdIn;
            rwOut_d = regWrIn;
          end else if (!aligned) begin
            ov_d    = 1'b1;
            mis_d   = 1'b1;
            wb_d    = aluOut;
            rdOut_d = rdIn;
            rwOut_d = 1'b0;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            addr_d  = aluOut;
            ctrl_d  = memCtrl;
            we_d    = memWr;
            wdata_d = lane_wdata(memCtrl, r2);
            be_d    = lane_be(memCtrl, aluOut[1:0]);
            rd_d    = rdIn;
            rw_d    = regWrIn;
          end
        end
      end
      BUSY: begin
        if (dbus.dAck) begin
          state_d = IDLE;
          cnt_d   = '0;
          ov_d    = 1'b1;
          rdOut_d = rd_q;
          rwOut_d = rw_q;
          wb_d    = we_q ? addr_q : load_extract(ctrl_q, addr_q[1:0], dbus.dRdata);
        end else if (to_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          ov_d    = 1'b1;
          berr_d  = 1'b1;
          rdOut_d = rd_q;
          rwOut_d = 1'b0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ctrl_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ov_q    <= 1'b0;
      rdOut_q <= '0;
      rwOut_q <= 1'b0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ctrl_q  <= ctrl_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ov_q    <= ov_d;
      rdOut_q <= rdOut_d;
      rwOut_q <= rwOut_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for the memory-access stage: expected write-back results are queued
// when an instruction is driven and compared when outValid pulses.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        memRd = 1'b0;
  logic        memWr = 1'b0;
  logic [2:0]  memCtrl = 3'b000;
  logic [31:0] aluOut = 32'd0;
  logic [31:0] r2 = 32'd0;
  logic [4:0]  rdIn = 5'd0;
  logic        regWrIn = 1'b0;
  logic        stall;
  logic        outValid;
  logic [4:0]  rdOut;
  logic        regWrOut;
  logic [31:0] wbData;
  logic        misalign;
  logic        busErr;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .memRd    (memRd),
    .memWr    (memWr),
    .memCtrl  (memCtrl),
    .aluOut   (aluOut),
    .r2       (r2),
    .rdIn     (rdIn),
    .regWrIn  (regWrIn),
    .stall    (stall),
    .dbus     (bus.master),
    .outValid (outValid),
    .rdOut    (rdOut),
    .regWrOut (regWrOut),
    .wbData   (wbData),
    .misalign (misalign),
    .busErr   (busErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic        chk_wb;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference models of the lane logic.
  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] a,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (32'(a) * 8));
    h = a[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  m_load = {{24{b[7]}}, b};
      3'b100:  m_load = {24'h0, b};
      3'b001:  m_load = {{16{h[15]}}, h};
      3'b101:  m_load = {16'h0, h};
      default: m_load = d;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [1:0] a);
    if (f == 3'b000 || f == 3'b100)      m_be = 4'(1 << a);
    else if (f == 3'b001 || f == 3'b101) m_be = a[1] ? 4'hC : 4'h3;
    else                                 m_be = 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'b000 || f == 3'b100)      m_wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
    else if (f == 3'b001 || f == 3'b101) m_wd = {d[15:0], d[15:0]};
    else                                 m_wd = d;
  endfunction

  // Write-back monitor.
  always @(negedge clk) begin
    exp_t e;
    if (outValid) begin
      if (sb.size() == 0) begin
        check("spurious_outValid", 32'(outValid), 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_wb) check("wbData", wbData, e.wb);
        check("rdOut", 32'(rdOut), 32'(e.rd));
        check("regWrOut", 32'(regWrOut), 32'(e.rw));
        check("misalign", 32'(misalign), 32'(e.mis));
        check("busErr", 32'(busErr), 32'(e.berr));
      end
    end
  end

  task automatic do_alu(input logic [31:0] v, input logic [4:0] rdv, input logic rw);
    sb.push_back('{wb: v, chk_wb: 1'b1, rd: rdv, rw: rw, mis: 1'b0, berr: 1'b0});
    inValid = 1'b1; memRd = 1'b0; memWr = 1'b0;
    aluOut = v; rdIn = rdv; regWrIn = rw;
    @(negedge clk);
    check("alu_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("alu_latency", 32'(outValid), 32'd1);
    inValid = 1'b0;
  endtask

  task automatic do_mis(input logic wr, input logic [2:0] f, input logic [31:0] a,
                        input logic [4:0] rdv);
    sb.push_back('{wb: 32'd0, chk_wb: 1'b0, rd: rdv, rw: 1'b0, mis: 1'b1, berr: 1'b0});
    inValid = 1'b1; memRd = ~wr; memWr = wr; memCtrl = f;
    aluOut = a; rdIn = rdv; regWrIn = 1'b1;
    @(negedge clk);
    check("mis_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("mis_outValid", 32'(outValid), 32'd1);
    check("mis_dReq", 32'(bus.dReq), 32'd0);
    inValid = 1'b0; memRd = 1'b0; memWr = 1'b0;
  endtask

  // Runs one aligned access; the ack arrives after wait_cyc BUSY cycles.
  task automatic do_mem(input logic wr, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rdv, input logic rw,
                        input int wait_cyc, input logic [31:0] rdata);
    sb.push_back('{wb: wr ? a : m_load(f, a[1:0], rdata), chk_wb: 1'b1,
                   rd: rdv, rw: rw, mis: 1'b0, berr: 1'b0});
    inValid = 1'b1; memRd = ~wr; memWr = wr; memCtrl = f;
    aluOut = a; r2 = d; rdIn = rdv; regWrIn = rw;
    @(negedge clk);
    check("acc_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("busy_outValid", 32'(outValid), 32'd0);
    aluOut = ~a; r2 = ~d; rdIn = ~rdv; memCtrl = 3'b010;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_dReq", 32'(bus.dReq), 32'd1);
      @(posedge clk); #1;
    end
    bus.dAck = 1'b1; bus.dRdata = rdata;
    @(negedge clk);
    check("dReq", 32'(bus.dReq), 32'd1);
    check("dWe", 32'(bus.dWe), 32'(wr));
    check("dAddr", bus.dAddr, {a[31:2], 2'b00});
    check("dBe", 32'(bus.dBe), 32'(m_be(f, a[1:0])));
    if (wr) check("dWdata", bus.dWdata, m_wd(f, d));
    check("ack_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("ack_outValid", 32'(outValid), 32'd1);
    check("ack_dReq", 32'(bus.dReq), 32'd0);
    bus.dAck = 1'b0; bus.dRdata = $urandom;
    inValid = 1'b0; memRd = 1'b0; memWr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ctab [5];
    logic [2:0]  f;
    logic [31:0] a;
    logic        wr;
    int          cnt;
    ctab[0] = 3'b000; ctab[1] = 3'b001; ctab[2] = 3'b010; ctab[3] = 3'b100; ctab[4] = 3'b101;
    bus.dAck = 1'b0; bus.dRdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dReq", 32'(bus.dReq), 32'd0);
    check("rst_dWe", 32'(bus.dWe), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_dAddr", bus.dAddr, 32'd0);
    check("rst_dBe", 32'(bus.dBe), 32'd0);
    check("rst_wbData", wbData, 32'd0);
    check("rst_rdOut", 32'(rdOut), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Ack while idle does nothing
    bus.dAck = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_ack_dReq", 32'(bus.dReq), 32'd0);
    bus.dAck = 1'b0;

    // Pass-through ops, back to back
    do_alu(32'h0000_1234, 5'd5, 1'b1);
    do_alu(32'hCAFE_F00D, 5'd31, 1'b0);
    do_alu(32'h8000_0001, 5'd1, 1'b1);
    @(negedge clk);
    check("alu_hold_wb", wbData, 32'h8000_0001);

    // Directed loads and stores
    do_mem(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd3, 1'b1, 0, 32'h80FF_FF7F);
    do_mem(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 1'b0, 2, 32'd0);
    do_mem(1'b0, 3'b100, 32'h0000_1003, 32'd0, 5'd4, 1'b1, 1, 32'h80FF_FF7F);
    do_mem(1'b0, 3'b001, 32'h0000_3002, 32'd0, 5'd6, 1'b1, 0, 32'h8123_4567);
    do_mem(1'b0, 3'b101, 32'h0000_3002, 32'd0, 5'd7, 1'b1, 0, 32'h8123_4567);
    do_mem(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd8, 1'b1, 3, 32'hDEAD_BEEF);
    do_mem(1'b1, 3'b000, 32'h0000_5001, 32'h0000_005A, 5'd0, 1'b0, 0, 32'd0);
    do_mem(1'b0, 3'b111, 32'h0000_6004, 32'd0, 5'd9, 1'b1, 0, 32'h1357_9BDF);

    // Misaligned accesses
    do_mis(1'b0, 3'b010, 32'h0000_0006, 5'd10);
    do_mis(1'b0, 3'b001, 32'h0000_0011, 5'd11);
    do_mis(1'b1, 3'b010, 32'h0000_0001, 5'd12);

    // Ack in the last allowed BUSY cycle wins over the timeout
    do_mem(1'b0, 3'b010, 32'h0000_7000, 32'd0, 5'd13, 1'b1, 15, 32'h0BAD_F00D);

    // Timeout with no ack, then a late ack
    sb.push_back('{wb: 32'd0, chk_wb: 1'b0, rd: 5'd14, rw: 1'b0, mis: 1'b0, berr: 1'b1});
    inValid = 1'b1; memRd = 1'b1; memWr = 1'b0; memCtrl = 3'b010;
    aluOut = 32'h0000_0100; rdIn = 5'd14; regWrIn = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; memRd = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.dReq) cnt++;
      else break;
    end
    check("to_dReq_cycles", 32'(cnt), 32'd16);
    check("to_busErr", 32'(busErr), 32'd1);
    @(posedge clk); #1 bus.dAck = 1'b1;
    @(negedge clk);
    check("late_ack_dReq", 32'(bus.dReq), 32'd0);
    @(posedge clk); #1 bus.dAck = 1'b0;
    check("late_ack_outValid", 32'(outValid), 32'd0);

    // Reset during the second BUSY cycle of an LHU
    inValid = 1'b1; memRd = 1'b1; memCtrl = 3'b101;
    aluOut = 32'h0000_2002; rdIn = 5'd15; regWrIn = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; memRd = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy_dReq_before", 32'(bus.dReq), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    check("rst_busy_dReq_after", 32'(bus.dReq), 32'd0);
    check("rst_busy_stall", 32'(stall), 32'd0);
    bus.dAck = 1'b1;
    @(posedge clk); #1 bus.dAck = 1'b0;
    check("rst_busy_outValid", 32'(outValid), 32'd0);
    check("rst_busy_dReq_idle", 32'(bus.dReq), 32'd0);

    // Random mix of accesses and pass-through ops
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      f  = wr ? ctab[$urandom_range(0, 2)] : ctab[$urandom_range(0, 4)];
      a  = $urandom;
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      else if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      if (n % 5 == 4) do_alu($urandom, 5'($urandom), 1'b1);
      else do_mem(wr, f, a, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
